pcs_rx_sync: RTL
================

Name: pcs_rx_sync

Overview:
- Receive-side code-group synchronization stage for the 1000BASE-X PCS. It sits directly downstream of the transmitter and consumes its 10-bit code_group stream.
- Checks each code-group against 8b/10b sub-block rules and tracks running disparity.
- Runs the comma-based acquire/lose synchronization FSM.
- Emits sync_status, even/odd alignment and a registered copy of the code-group for the receive state machine.

Parameters:
- ERR_LOSS, 4, consecutive-unrecovered error count that forces loss of sync.
- GOOD_RECOVER, 4, consecutive valid code-groups that cancel one pending error.

Ports:
- GTX_CLK  input  1  single clock; one code-group sampled per rising edge.
- RESET  input  1  asynchronous, active-low reset.
- rx_code_group  input  10  incoming code-group. Bit 9 = a, bit 0 = j; bit 9 is first on the line.
- rx_code_group_o  output  10  registered copy of rx_code_group.
- cg_valid  output  1  sampled code-group is valid under the current running disparity.
- comma_det  output  1  sampled code-group contains a comma.
- rx_even  output  1  alignment of the sampled code-group; 1 = even position.
- sync_status  output  1  1 = OK, 0 = FAIL.
- rd_pos  output  1  running disparity after this code-group; 1 = positive.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=LOSS_OF_SYNC; RD negative; err_cnt=0; good_cnt=0.
  - All outputs 0, rx_code_group_o=0.
- Latency: every output is registered and reflects the code-group sampled at the same edge, one cycle after it is presented.
- Comma detection: bits [9:3] equal 7'b0011111 or 7'b1100000.
- Validity check:
  - 6b sub-block [9:4] must be a member of the Clause 36 5b/6b set for the current RD.
  - 4b sub-block [3:0] must be a member of the 3b/4b set for the RD after the 6b block. Both primary and alternate x.7 encodings are accepted.
  - Data and K codes are both legal.
- RD update, per sub-block, applied to valid and invalid code-groups alike:
  - Result is positive if ones>zeros, or if the block is 000111 / 0011.
  - Result is negative if zeros>ones, or if the block is 111000 / 1100.
  - Otherwise RD is unchanged.
- Bad code-group (cgbad): invalid, OR comma at an odd position. cggood = !cgbad.
- rx_even:
  - A comma accepted in the COMMA_DETECT states forces rx_even=1.
  - In every other state rx_even toggles each cycle.
- FSM transitions (evaluated on each sampled code-group):
  - LOSS_OF_SYNC: comma -> COMMA_DETECT_1; otherwise stay. rx_even toggles.
  - COMMA_DETECT_n (n=1..3): valid non-comma -> ACQUIRE_SYNC_n (SYNC_ACQUIRED_1 when n=3). Any other code-group -> LOSS_OF_SYNC.
  - ACQUIRE_SYNC_n (n=1,2):
    - Comma at even position -> COMMA_DETECT_(n+1).
    - cgbad -> LOSS_OF_SYNC.
    - Valid non-comma -> stay.
  - SYNC_ACQUIRED: single state with counters err_cnt (0..ERR_LOSS-1) and good_cnt.
    - cgbad: err_cnt++ and good_cnt=0. If err_cnt reaches ERR_LOSS -> LOSS_OF_SYNC.
    - cggood with err_cnt>0: good_cnt++. When good_cnt reaches GOOD_RECOVER: err_cnt-- and good_cnt=0.
    - cggood with err_cnt=0: good_cnt held at 0.
- sync_status:
  - 1 exactly when the registered state is SYNC_ACQUIRED.
  - Drops to 0 on the same edge that sets LOSS_OF_SYNC; err_cnt and good_cnt clear at that edge.
- Reset mid-operation: immediate return to the reset values above, regardless of state.

Test Plan:
1. RESET=0 for 3 cycles with random rx_code_group -> all outputs 0, rd_pos=0. Release -> first code-group 0011111010 gives comma_det=1, rx_even=1, rd_pos=1.
2. Idle stream alternating 0011111010 (K28.5-) and 1001000101 (D16.2+) -> sync_status=1 on the output cycle of the 6th code-group. cg_valid=1 throughout; rd_pos alternates 1,0; rx_even alternates 1,0.
3. Synced idle, then one 0000000000 -> cg_valid=0, sync_status stays 1. Next 4 idle code-groups clear err_cnt; then 3 bad -> sync_status still 1.
4. Synced idle, then 4 consecutive 0000000000 -> sync_status=0 on the 4th. Resuming idle re-acquires 6 code-groups later.
5. Synced, then K28.5 injected at an odd position -> treated as cgbad, rx_even keeps toggling. Three more bad code-groups -> sync_status=0.
6. Assert RESET during ACQUIRE_SYNC_2 -> outputs 0 asynchronously. After release, the full 6-code-group acquisition is required again.

Source files
------------

// File: rtl/pcs_rx_sync.sv
// 1000BASE-X PCS receive code-group synchronization: 8b/10b sub-block validity
// and running-disparity tracking, plus the comma-based acquire/lose sync FSM.
`timescale 1ns/1ps

module pcs_rx_sync #(
  parameter int ERR_LOSS     = 4,
  parameter int GOOD_RECOVER = 4
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic [9:0] rx_code_group,
  output logic [9:0] rx_code_group_o,
  output logic       cg_valid,
  output logic       comma_det,
  output logic       rx_even,
  output logic       sync_status,
  output logic       rd_pos
);

  localparam int EW = (ERR_LOSS > 1) ? $clog2(ERR_LOSS) : 1;
  localparam int GW = (GOOD_RECOVER > 1) ? $clog2(GOOD_RECOVER) : 1;
  localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LOSS - 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(GOOD_RECOVER - 1);

  typedef enum logic [2:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT_1,
    COMMA_DETECT_2,
    COMMA_DETECT_3,
    ACQUIRE_SYNC_1,
    ACQUIRE_SYNC_2,
    SYNC_ACQUIRED
  } state_t;

  function automatic logic [2:0] ones6(input logic [5:0] b);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, b[i]};
    return n;
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] b);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, b[i]};
    return n;
  endfunction

  // 5b/6b legality: balanced codes are legal at either disparity, the rest
  // only in the column matching the current running disparity.
  function automatic logic valid6(input logic [5:0] b, input logic rd);
    logic neutral;
    logic unbal;
    case (b)
      6'b110001, 6'b101001, 6'b011001, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b100011, 6'b010011, 6'b110010,
      6'b001011, 6'b101010, 6'b011010, 6'b100110, 6'b010110, 6'b001110:
        neutral = 1'b1;
      default: neutral = 1'b0;
    endcase
    if (!rd) begin
      case (b)
        6'b100111, 6'b011101, 6'b101101, 6'b110101, 6'b111000, 6'b111001,
        6'b010111, 6'b011011, 6'b111010, 6'b110011, 6'b110110, 6'b101110,
        6'b011110, 6'b101011, 6'b001111:
          unbal = 1'b1;
        default: unbal = 1'b0;
      endcase
    end else begin
      case (b)
        6'b011000, 6'b100010, 6'b010010, 6'b001010, 6'b000111, 6'b000110,
        6'b101000, 6'b100100, 6'b000101, 6'b001100, 6'b001001, 6'b010001,
        6'b100001, 6'b010100, 6'b110000:
          unbal = 1'b1;
        default: unbal = 1'b0;
      endcase
    end
    return neutral | unbal;
  endfunction

  // 3b/4b legality, primary and alternate x.7 both accepted.
  function automatic logic valid4(input logic [3:0] b, input logic rd);
    logic ok;
    // NOTE: every path assigns ok, so no storage is implied by this decode.
    case (b)
      4'b1001, 4'b0101, 4'b1010, 4'b0110: ok = 1'b1;
      4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b0111: ok = !rd;
      4'b0100, 4'b0011, 4'b0010, 4'b0001, 4'b1000: ok = rd;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic next_rd6(input logic [5:0] b, input logic rd);
    logic [2:0] n;
    n = ones6(b);
    if (n > 3'd3 || b == 6'b000111) return 1'b1;
    if (n < 3'd3 || b == 6'b111000) return 1'b0;
    return rd;
  endfunction

  function automatic logic next_rd4(input logic [3:0] b, input logic rd);
    logic [2:0] n;
    n = ones4(b);
    if (n > 3'd2 || b == 4'b0011) return 1'b1;
    if (n < 3'd2 || b == 4'b1100) return 1'b0;
    return rd;
  endfunction

  state_t          r_state;
  logic            r_rd;
  logic            r_even;
  logic [EW-1:0]   r_err_cnt;
  logic [GW-1:0]   r_good_cnt;
  logic [9:0]      r_cg;
  logic            r_valid;
  logic            r_comma;

  logic w_comma;
  logic w_rd_mid;
  logic w_rd_new;
  logic w_valid;
  logic w_even_pos;
  logic w_cgbad;

  assign w_comma    = (rx_code_group[9:3] == 7'b0011111) ||
                      (rx_code_group[9:3] == 7'b1100000);
  assign w_rd_mid   = next_rd6(rx_code_group[9:4], r_rd);
  assign w_rd_new   = next_rd4(rx_code_group[3:0], w_rd_mid);
  assign w_valid    = valid6(rx_code_group[9:4], r_rd) &&
                      valid4(rx_code_group[3:0], w_rd_mid);
  // The incoming code-group occupies the position after the last one.
  assign w_even_pos = ~r_even;
  assign w_cgbad    = !w_valid || (w_comma && !w_even_pos);

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= LOSS_OF_SYNC;
      r_rd       <= 1'b0;
      r_even     <= 1'b0;
      r_err_cnt  <= '0;
      r_good_cnt <= '0;
      r_cg       <= '0;
      r_valid    <= 1'b0;
      r_comma    <= 1'b0;
    end else begin
      r_cg    <= rx_code_group;
      r_valid <= w_valid;
      r_comma <= w_comma;
      r_rd    <= w_rd_new;
      // NOTE: default toggle; a later non-blocking write in the case below
      // overrides it because the last scheduled update to a register wins.
      r_even  <= ~r_even;

      case (r_state)
        LOSS_OF_SYNC: begin
          if (w_comma) begin
            r_state <= COMMA_DETECT_1;
            r_even  <= 1'b1;
          end
        end
        COMMA_DETECT_1: r_state <= (w_valid && !w_comma) ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
        COMMA_DETECT_2: r_state <= (w_valid && !w_comma) ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
        COMMA_DETECT_3: r_state <= (w_valid && !w_comma) ? SYNC_ACQUIRED  : LOSS_OF_SYNC;
        ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: begin
          if (w_comma && w_even_pos) begin
            r_state <= (r_state == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
            r_even  <= 1'b1;
          end else if (w_cgbad) begin
            r_state <= LOSS_OF_SYNC;
          end
        end
        SYNC_ACQUIRED: begin
          if (w_cgbad) begin
            r_good_cnt <= '0;
            if (r_err_cnt == ERR_MAX) begin
              r_state   <= LOSS_OF_SYNC;
              r_err_cnt <= '0;
            end else begin
              r_err_cnt <= r_err_cnt + EW'(1);
            end
          end else if (r_err_cnt != '0) begin
            // A run of good code-groups forgives one outstanding error.
            if (r_good_cnt == GOOD_MAX) begin
              r_err_cnt  <= r_err_cnt - EW'(1);
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GW'(1);
            end
          end else begin
            r_good_cnt <= '0;
          end
        end
        default: r_state <= LOSS_OF_SYNC;
      endcase
    end
  end

  assign rx_code_group_o = r_cg;
  assign cg_valid        = r_valid;
  assign comma_det       = r_comma;
  assign rx_even         = r_even;
  assign rd_pos          = r_rd;
  assign sync_status     = (r_state == SYNC_ACQUIRED);

endmodule
